// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver: FSM states,
// prefix bytes and the buffered entry layout.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_REL = 8'hF0;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } ps2_entry_t;

   // PS/2 frames carry odd parity across the eight data bits plus the parity bit.
   function automatic logic frameParityOk(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronisers for the PS/2 lines plus a glitch filter on the clock
// line that produces a clean level and a one-cycle falling-edge strobe.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic n_reset,
   input  logic ps2Clk,
   input  logic ps2Data,
   output logic clkLevel,
   output logic dataSync,
   output logic fallStrobe
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clkSync_q;
   logic [1:0]    dataSync_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;
   logic          fall_q;

   // Lines idle high, so the synchronisers and filtered level reset to 1 to
   // avoid a spurious edge after reset.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         clkSync_q  <= 2'b11;
         dataSync_q <= 2'b11;
         level_q    <= 1'b1;
         cnt_q      <= '0;
         fall_q     <= 1'b0;
      end else begin
         clkSync_q  <= {clkSync_q[0], ps2Clk};
         dataSync_q <= {dataSync_q[0], ps2Data};
         fall_q     <= 1'b0;
         if (clkSync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_q <= clkSync_q[1];
            cnt_q   <= '0;
            fall_q  <= level_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign clkLevel   = level_q;
   assign dataSync   = dataSync_q[1];
   assign fallStrobe = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver with E0/F0 prefix folding and an output buffer.
// Define PS2_RX_FIFO_EN for a 4-entry FWFT FIFO; otherwise a single holding register.
import ps2_pkg::*;

module ps2_scancode_rx #(
   parameter int CLK_HZ     = 50000000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 200
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic [7:0] scan_code,
   output logic       extended,
   output logic       released,
   output logic       valid,
   input  logic       ready,
   output logic       rx_err,
   output logic       overrun
);

   localparam logic [31:0] TIMEOUT_CYC =
      32'((64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000);

   logic clkLevel, dataSync, fallStrobe;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (clk),
      .n_reset   (n_reset),
      .ps2Clk    (ps2Clk),
      .ps2Data   (ps2Data),
      .clkLevel  (clkLevel),
      .dataSync  (dataSync),
      .fallStrobe(fallStrobe)
   );

   ps2_state_e  state_q, state_d;
   logic [2:0]  bitCnt_q, bitCnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        parity_q, parity_d;
   logic [31:0] timer_q, timer_d;
   logic        frameDone_q, frameDone_d;
   logic        frameOk_q, frameOk_d;
   logic        extPend_q, extPend_d;
   logic        relPend_q, relPend_d;
   logic        rxErr_q, rxErr_d;
   logic        overrun_q;
   logic        timeoutHit;
   logic        wrEn;
   logic        bufFull;
   logic        pop;
   ps2_entry_t  wrEntry;

   assign timeoutHit = (state_q != ST_IDLE) && !fallStrobe && (timer_q >= TIMEOUT_CYC - 32'd1);
   assign wrEntry    = '{code: shift_q, ext: extPend_q, rel: relPend_q};

   // Frame decoding happens on filtered falling edges; the completed byte is
   // classified one cycle later, which is when buffer writes occur.
   always_comb begin
      state_d     = state_q;
      bitCnt_d    = bitCnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      frameOk_d   = frameOk_q;
      extPend_d   = extPend_q;
      relPend_d   = relPend_q;
      frameDone_d = 1'b0;
      rxErr_d     = 1'b0;
      wrEn        = 1'b0;
      timer_d     = (state_q == ST_IDLE || fallStrobe) ? 32'd0 : timer_q + 32'd1;

      if (timeoutHit) begin
         state_d   = ST_IDLE;
         rxErr_d   = 1'b1;
         extPend_d = 1'b0;
         relPend_d = 1'b0;
         timer_d   = 32'd0;
      end else if (fallStrobe) begin
         case (state_q)
            ST_IDLE: begin
               if (!dataSync) begin
                  state_d  = ST_DATA;
                  bitCnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d  = {dataSync, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               parity_d = dataSync;
               state_d  = ST_STOP;
            end
            default: begin
               state_d     = ST_IDLE;
               frameDone_d = 1'b1;
               frameOk_d   = frameParityOk(shift_q, parity_q) && dataSync;
            end
         endcase
      end

      if (frameDone_q) begin
         if (!frameOk_q) begin
            rxErr_d   = 1'b1;
            extPend_d = 1'b0;
            relPend_d = 1'b0;
         end else if (shift_q == PS2_PFX_EXT) begin
            extPend_d = 1'b1;
         end else if (shift_q == PS2_PFX_REL) begin
            relPend_d = 1'b1;
         end else begin
            wrEn      = 1'b1;
            extPend_d = 1'b0;
            relPend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q     <= ST_IDLE;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         timer_q     <= '0;
         frameDone_q <= 1'b0;
         frameOk_q   <= 1'b0;
         extPend_q   <= 1'b0;
         relPend_q   <= 1'b0;
         rxErr_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitCnt_q    <= bitCnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         timer_q     <= timer_d;
         frameDone_q <= frameDone_d;
         frameOk_q   <= frameOk_d;
         extPend_q   <= extPend_d;
         relPend_q   <= relPend_d;
         rxErr_q     <= rxErr_d;
         overrun_q   <= wrEn && bufFull && !pop;
      end
   end

   assign pop     = valid && ready;
   assign rx_err  = rxErr_q;
   assign overrun = overrun_q;

`ifdef PS2_RX_FIFO_EN
   ps2_entry_t mem_q [4];
   logic [1:0] wrPtr_q, rdPtr_q;
   logic [2:0] count_q;
   logic       push;

   assign bufFull = (count_q == 3'd4);
   assign push    = wrEn && (!bufFull || pop);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_q[wrPtr_q] <= wrEntry;
            wrPtr_q        <= wrPtr_q + 2'd1;
         end
         if (pop) rdPtr_q <= rdPtr_q + 2'd1;
         count_q <= count_q + 3'(push) - 3'(pop);
      end
   end

   assign valid     = (count_q != 3'd0);
   assign scan_code = mem_q[rdPtr_q].code;
   assign extended  = mem_q[rdPtr_q].ext;
   assign released  = mem_q[rdPtr_q].rel;
`else
   ps2_entry_t hold_q;
   logic       full_q;

   assign bufFull = full_q;

   // A write while full is only accepted when the current entry is popped in
   // the same cycle, so existing contents never get overwritten.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else if (wrEn && (!full_q || pop)) begin
         hold_q <= wrEntry;
         full_q <= 1'b1;
      end else if (pop) begin
         full_q <= 1'b0;
      end
   end

   assign valid     = full_q;
   assign scan_code = hold_q.code;
   assign extended  = hold_q.ext;
   assign released  = hold_q.rel;
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed testbench for ps2_scancode_rx: good frames, prefixes, parity error,
// timeout, overrun and mid-frame reset.
module tb_ps2_scancode_rx;

   localparam int CLK_HZ     = 1000000;
   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT_US = 200;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] scan_code;
   logic       extended, released, valid, rx_err, overrun;

   int checks = 0;
   int failures = 0;
   int errCount = 0;
   int ovrCount = 0;
   int errBase;

   ps2_scancode_rx #(
      .CLK_HZ    (CLK_HZ),
      .FILTER_LEN(FILTER_LEN),
      .TIMEOUT_US(TIMEOUT_US)
   ) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .ps2Clk   (ps2Clk),
      .ps2Data  (ps2Data),
      .scan_code(scan_code),
      .extended (extended),
      .released (released),
      .valid    (valid),
      .ready    (ready),
      .rx_err   (rx_err),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rx_err)  errCount++;
      if (overrun) ovrCount++;
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives the first nBits bits of a frame: start, 8 data LSB-first, parity, stop.
   task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic stopBit, input int nBits);
      logic [10:0] frame;
      frame = {stopBit, parity, data, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         ps2Data = frame[i];
         waitCycles(10);
         ps2Clk = 1'b0;
         waitCycles(20);
         ps2Clk = 1'b1;
         waitCycles(10);
      end
      ps2Data = 1'b1;
      waitCycles(5);
   endtask

   task automatic sendByte(input logic [7:0] data);
      applyStimulus(data, ~^data, 1'b1, 11);
   endtask

   task automatic popEntry();
      @(negedge clk) ready = 1'b1;
      @(negedge clk) ready = 1'b0;
   endtask

   task automatic checkEntry(input string tag, input logic [7:0] code, input logic ext, input logic rel);
      checkOutput({tag, "_valid"}, 16'(valid), 16'd1);
      checkOutput({tag, "_code"}, 16'(scan_code), 16'(code));
      checkOutput({tag, "_ext"}, 16'(extended), 16'(ext));
      checkOutput({tag, "_rel"}, 16'(released), 16'(rel));
   endtask

   initial begin
      waitCycles(4);
      checkOutput("rst_code", 16'(scan_code), 16'h00);
      checkOutput("rst_ext", 16'(extended), 16'd0);
      checkOutput("rst_rel", 16'(released), 16'd0);
      checkOutput("rst_valid", 16'(valid), 16'd0);
      checkOutput("rst_err", 16'(rx_err), 16'd0);
      checkOutput("rst_ovr", 16'(overrun), 16'd0);
      n_reset = 1'b1;
      waitCycles(5);

      sendByte(8'h1C);
      checkEntry("plain1C", 8'h1C, 1'b0, 1'b0);
      waitCycles(50);
      checkEntry("hold1C", 8'h1C, 1'b0, 1'b0);
      popEntry();
      checkOutput("pop1C_valid", 16'(valid), 16'd0);

      sendByte(8'hF0);
      checkOutput("pfxF0_novalid", 16'(valid), 16'd0);
      sendByte(8'h1C);
      checkEntry("brk1C", 8'h1C, 1'b0, 1'b1);
      popEntry();
      checkOutput("brk1C_single", 16'(valid), 16'd0);

      sendByte(8'hE0);
      sendByte(8'hF0);
      sendByte(8'h75);
      checkEntry("extbrk75", 8'h75, 1'b1, 1'b1);
      popEntry();
      checkOutput("extbrk75_single", 16'(valid), 16'd0);

      errBase = errCount;
      applyStimulus(8'h1C, 1'b1, 1'b1, 11);
      checkOutput("parity_err", 16'(errCount - errBase), 16'd1);
      checkOutput("parity_novalid", 16'(valid), 16'd0);
      sendByte(8'h32);
      checkEntry("after_par32", 8'h32, 1'b0, 1'b0);
      popEntry();

      errBase = errCount;
      applyStimulus(8'h29, 1'b0, 1'b1, 5);
      waitCycles(300);
      checkOutput("timeout_err", 16'(errCount - errBase), 16'd1);
      checkOutput("timeout_novalid", 16'(valid), 16'd0);
      sendByte(8'h29);
      checkEntry("after_to29", 8'h29, 1'b0, 1'b0);
      popEntry();

`ifdef PS2_RX_FIFO_EN
      sendByte(8'h1C);
      sendByte(8'h32);
      sendByte(8'h29);
      sendByte(8'h75);
      sendByte(8'h16);
      checkOutput("ovr_pulse", 16'(ovrCount), 16'd1);
      checkEntry("drain0", 8'h1C, 1'b0, 1'b0);
      popEntry();
      checkEntry("drain1", 8'h32, 1'b0, 1'b0);
      popEntry();
      checkEntry("drain2", 8'h29, 1'b0, 1'b0);
      popEntry();
      checkEntry("drain3", 8'h75, 1'b0, 1'b0);
      popEntry();
`else
      sendByte(8'h1C);
      sendByte(8'h32);
      checkOutput("ovr_pulse", 16'(ovrCount), 16'd1);
      checkEntry("drain0", 8'h1C, 1'b0, 1'b0);
      popEntry();
`endif
      checkOutput("drain_empty", 16'(valid), 16'd0);

      sendByte(8'hE0);
      applyStimulus(8'h1C, 1'b0, 1'b1, 5);
      n_reset = 1'b0;
      waitCycles(3);
      checkOutput("midrst_code", 16'(scan_code), 16'h00);
      checkOutput("midrst_ext", 16'(extended), 16'd0);
      checkOutput("midrst_rel", 16'(released), 16'd0);
      checkOutput("midrst_valid", 16'(valid), 16'd0);
      checkOutput("midrst_err", 16'(rx_err), 16'd0);
      checkOutput("midrst_ovr", 16'(overrun), 16'd0);
      n_reset = 1'b1;
      waitCycles(5);
      sendByte(8'h1C);
      checkEntry("postrst1C", 8'h1C, 1'b0, 1'b0);
      popEntry();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency used to derive the timeout.
REQ-002 SHALL have parameter FILTER_LEN, default 8, number of consecutive equal samples required to accept a ps2Clk level.
REQ-003 SHALL have parameter TIMEOUT_US, default 200, maximum gap between falling ps2Clk edges inside a frame.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic is in this one clock domain.
REQ-005 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ps2Clk, input, 1, PS/2 clock line, asynchronous to clk.
REQ-007 SHALL have port ps2Data, input, 1, PS/2 data line, asynchronous to clk.
REQ-008 SHALL have port scan_code, output, 8, completed scancode byte with prefixes removed.
REQ-009 SHALL have port extended, output, 1, set when the code was preceded by E0.
REQ-010 SHALL have port released, output, 1, set when the code was preceded by F0 (break code).
REQ-011 SHALL have port valid, output, 1, set when scan_code, extended and released hold an unread entry.
REQ-012 SHALL have port ready, input, 1, consumer accept; a transfer occurs on a cycle where valid and ready are both 1.
REQ-013 SHALL have port rx_err, output, 1, one-cycle pulse on a parity, start-bit, stop-bit or timeout error.
REQ-014 SHALL have port overrun, output, 1, one-cycle pulse when a completed code is dropped because the buffer is full.

Function
REQ-015 SHALL pass ps2Clk and ps2Data through two flip-flop synchronisers, then apply the FILTER_LEN glitch filter to ps2Clk.
REQ-016 SHALL sample the synchronised ps2Data on each filtered 1-to-0 transition of ps2Clk.
REQ-017 SHALL implement the receive FSM with states IDLE, DATA, PARITY and STOP:
- IDLE to DATA on a sampled 0 (start bit); a sampled 1 is ignored.
- DATA collects 8 bits LSB-first, then moves to PARITY.
- PARITY captures the bit, then moves to STOP.
- STOP returns to IDLE.
REQ-018 SHALL accept a frame only when data bits plus the parity bit have odd parity and the stop bit is 1; otherwise it SHALL discard the frame, pulse rx_err and clear the prefix flags.
REQ-019 SHALL hold prefix flags: E0 sets ext_pend, F0 sets rel_pend, and neither prefix byte is output.
REQ-020 SHALL, for any other accepted byte, write {byte, ext_pend, rel_pend} into the buffer on the cycle after the stop-bit sample, then clear both flags.
REQ-021 SHALL, when the buffer is full, drop that entry, pulse overrun, clear both flags and leave existing buffer contents unchanged.
REQ-022 SHALL abort the frame when the FSM is outside IDLE and no filtered falling edge arrives for TIMEOUT_US*CLK_HZ/1e6 cycles: return to IDLE, pulse rx_err, clear the flags.
REQ-023 SHALL let a buffer write and a ready-pop in the same cycle both take effect, including when the buffer is full.
REQ-024 SHALL keep valid and the outputs stable while valid=1 and ready=0.

Reset
REQ-025 SHALL, while n_reset=0, force the FSM to IDLE and set bit count=0, flags=0, buffer empty, scan_code=0x00, extended=0, released=0, valid=0, rx_err=0 and overrun=0.
REQ-026 SHALL, on reset asserted mid-frame, discard the partial frame, and the first post-reset frame SHALL decode correctly.

Configuration
REQ-027 SHALL, with PS2_RX_FIFO_EN defined, buffer in a 4-entry FIFO with 10-bit entries, first-word fall-through, so valid=1 the cycle after the first write.
REQ-028 SHALL, without PS2_RX_FIFO_EN, buffer in a single holding register, which is full while valid=1.

Structure
REQ-029 SHALL place the FSM state enum, the prefix constants PS2_PFX_EXT=8'hE0 and PS2_PFX_REL=8'hF0, and the entry struct {code, ext, rel} in package ps2_pkg.
REQ-030 SHALL implement the synchroniser plus glitch filter as sub-module ps2_line_filter, producing a filtered level and a falling-edge strobe.

Verification
REQ-031 SHALL cover: frame 0x1C with parity 0 -> scan_code=0x1C, extended=0, released=0, valid=1 until ready.
REQ-032 SHALL cover: bytes F0,1C -> exactly one entry, 0x1C with released=1; E0,F0,75 -> 0x75 with extended=1 and released=1.
REQ-033 SHALL cover: frame 0x1C with parity 1 -> rx_err pulses once, valid stays 0, and a following good 0x32 gives 0x32.
REQ-034 SHALL cover: 5 bits then a gap longer than the timeout -> rx_err pulses, and a following good frame 0x29 decodes.
REQ-035 SHALL cover: ready=0 with 5 codes sent (FIFO) or 2 codes sent (no FIFO) -> overrun pulses once, and the first entries drain in order.
REQ-036 SHALL cover: n_reset pulsed at bit 4 -> all outputs at reset values, and the next 0x1C frame decodes.
